// File: rtl/sig_meas_pkg.sv
// Shared definitions for the signal measurement block: sample width,
// default window/hysteresis sizes and the measurement FSM state encoding.
package sig_meas_pkg;

  localparam int DW          = 8;
  localparam int WIN_LEN_DEF = 4096;
  localparam int CNT_W_DEF   = 13;
  localparam int HYST_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEAK   = 3'd1,
    ST_THR    = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sig_meas_if.sv
// ADC-side bus of the measurement block: sample input, start/busy/done
// handshake and the held measurement results.
interface sig_meas_if #(
  parameter int DW    = sig_meas_pkg::DW,
  parameter int CNT_W = sig_meas_pkg::CNT_W_DEF
);

  logic             start;
  logic [DW-1:0]    ad_data;
  logic             ad_clk;
  logic             busy;
  logic             done;
  logic [DW-1:0]    vmax;
  logic [DW-1:0]    vmin;
  logic [DW-1:0]    vpp;
  logic [CNT_W-1:0] period;
  logic             no_signal;

  // Controller / ADC side
  modport master (
    output start, ad_data,
    input  ad_clk, busy, done, vmax, vmin, vpp, period, no_signal
  );

  // Measurement block side
  modport slave (
    input  start, ad_data,
    output ad_clk, busy, done, vmax, vmin, vpp, period, no_signal
  );

endinterface

// File: rtl/sig_meas_xdet.sv
// Hysteresis crossing detector: arms when the sample drops to thr_lo or
// below and fires for one cycle when an armed sample reaches thr_hi.
module sig_meas_xdet #(
  parameter int DW = sig_meas_pkg::DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] s_i,
  input  logic [DW-1:0] thr_lo_i,
  input  logic [DW-1:0] thr_hi_i,
  output logic          fire_o
);

  logic arm_q, arm_d;
  logic fire;

  // Fire beats arm when both hold; disabling drops any pending arm
  always_comb begin
    fire  = en_i && arm_q && (s_i >= thr_hi_i);
    arm_d = arm_q;
    if (!en_i) begin
      arm_d = 1'b0;
    end else if (fire) begin
      arm_d = 1'b0;
    end else if (s_i <= thr_lo_i) begin
      arm_d = 1'b1;
    end
  end

  // Arm flag register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign fire_o = fire;

endmodule

// File: rtl/sig_meas.sv
// Two-pass ADC signal measurement: a peak pass over WIN_LEN samples finds
// vmax/vmin, then a period pass times two hysteresis crossings of the
// mid level. Results are held until the next measurement completes.
module sig_meas #(
  parameter int DW      = sig_meas_pkg::DW,
  parameter int WIN_LEN = sig_meas_pkg::WIN_LEN_DEF,
  parameter int CNT_W   = sig_meas_pkg::CNT_W_DEF,
  parameter int HYST    = sig_meas_pkg::HYST_DEF
) (
  input logic       clk_50M,
  input logic       rst_n,
  sig_meas_if.slave bus
);

  import sig_meas_pkg::*;

  localparam logic [DW-1:0]    HYST_V    = DW'(HYST);
  localparam logic [DW:0]      HYST2_V   = (DW+1)'(2 * HYST);
  localparam logic [CNT_W-1:0] WIN_END   = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(WIN_LEN - 1);

  // Mid level of max and min; the extra sum bit keeps the carry
  function automatic logic [DW-1:0] mid_level(input logic [DW-1:0] hi,
                                              input logic [DW-1:0] lo);
    logic [DW:0] sum;
    sum = {1'b0, hi} + {1'b0, lo};
    return sum[DW:1];
  endfunction

  // a - b clamped at the bottom of the range
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[DW] ? '0 : diff[DW-1:0];
  endfunction

  // a + b clamped at the top of the range
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DW] ? '1 : sum[DW-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [DW-1:0]    s_reg_q;
  logic [DW-1:0]    max_q, max_d, min_q, min_d;
  logic [DW-1:0]    thr_lo_q, thr_lo_d, thr_hi_q, thr_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             have_first_q, have_first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW-1:0]    vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             nosig_q, nosig_d;

  logic [DW-1:0]    span;
  logic [DW-1:0]    thr_mid;
  logic             xdet_en;
  logic             fire;
  logic             finish;
  logic [CNT_W-1:0] fin_period;
  logic             fin_nosig;

  assign span    = max_q - min_q;
  assign thr_mid = mid_level(max_q, min_q);
  assign xdet_en = (state_q == ST_PERIOD);

  sig_meas_xdet #(
    .DW (DW)
  ) u_xdet (
    .clk_i    (clk_50M),
    .rst_ni   (rst_n),
    .en_i     (xdet_en),
    .s_i      (s_reg_q),
    .thr_lo_i (thr_lo_q),
    .thr_hi_i (thr_hi_q),
    .fire_o   (fire)
  );

  // FSM state register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, trackers, counters and result loading
  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    min_d        = min_q;
    thr_lo_d     = thr_lo_q;
    thr_hi_d     = thr_hi_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    have_first_d = have_first_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    vmax_d       = vmax_q;
    vmin_d       = vmin_q;
    vpp_d        = vpp_q;
    period_d     = period_q;
    nosig_d      = nosig_q;
    finish       = 1'b0;
    fin_period   = '0;
    fin_nosig    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_PEAK;
          busy_d  = 1'b1;
          cnt_d   = '0;
          max_d   = '0;
          min_d   = '1;
        end
      end

      // Cycle 0 holds a sample registered at the entry edge; the window
      // proper is the following WIN_LEN samples
      ST_PEAK: begin
        if (cnt_q != '0) begin
          if (s_reg_q > max_q) max_d = s_reg_q;
          if (s_reg_q < min_q) min_d = s_reg_q;
        end
        if (cnt_q == WIN_END) begin
          state_d = ST_THR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_THR: begin
        thr_lo_d     = sat_sub(thr_mid, HYST_V);
        thr_hi_d     = sat_add(thr_mid, HYST_V);
        cnt_d        = '0;
        pcnt_d       = '0;
        have_first_d = 1'b0;
        if ({1'b0, span} < HYST2_V) begin
          finish = 1'b1;
        end else begin
          state_d = ST_PERIOD;
        end
      end

      // cnt is the timeout; pcnt measures distance from the first fire
      ST_PERIOD: begin
        cnt_d = cnt_q + 1'b1;
        if (fire && have_first_q) begin
          finish     = 1'b1;
          fin_period = pcnt_q + 1'b1;
          fin_nosig  = 1'b0;
        end else begin
          if (fire) begin
            pcnt_d       = '0;
            have_first_d = 1'b1;
          end else if (have_first_q) begin
            pcnt_d = pcnt_q + 1'b1;
          end
          if (cnt_q == TOUT_LAST) begin
            finish = 1'b1;
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d  = ST_DONE;
      done_d   = 1'b1;
      vmax_d   = max_q;
      vmin_d   = min_q;
      vpp_d    = span;
      period_d = fin_period;
      nosig_d  = fin_nosig;
    end
  end

  // Input sample register, trackers, counters and held results
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s_reg_q      <= '0;
      max_q        <= '0;
      min_q        <= '0;
      thr_lo_q     <= '0;
      thr_hi_q     <= '0;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      have_first_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vmax_q       <= '0;
      vmin_q       <= '0;
      vpp_q        <= '0;
      period_q     <= '0;
      nosig_q      <= 1'b0;
    end else begin
      s_reg_q      <= bus.ad_data;
      max_q        <= max_d;
      min_q        <= min_d;
      thr_lo_q     <= thr_lo_d;
      thr_hi_q     <= thr_hi_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      have_first_q <= have_first_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vmax_q       <= vmax_d;
      vmin_q       <= vmin_d;
      vpp_q        <= vpp_d;
      period_q     <= period_d;
      nosig_q      <= nosig_d;
    end
  end

  assign bus.ad_clk    = clk_50M;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vmax      = vmax_q;
  assign bus.vmin      = vmin_q;
  assign bus.vpp       = vpp_q;
  assign bus.period    = period_q;
  assign bus.no_signal = nosig_q;

endmodule

// File: tb/tb_sig_meas.sv
// Scoreboard bench for sig_meas with WIN_LEN=256, HYST=8: directed waveforms
// push expected results; a negedge monitor pops and compares on each done.
module tb_sig_meas;

  localparam int W  = 8;
  localparam int WL = 256;
  localparam int CW = 13;
  localparam int HY = 8;

  typedef struct {
    int vmax;
    int vmin;
    int vpp;
    int period;
    int nosig;
    int lat;
    int t_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sig_meas_if #(.DW(W), .CNT_W(CW)) bus ();

  sig_meas #(
    .DW      (W),
    .WIN_LEN (WL),
    .CNT_W   (CW),
    .HYST    (HY)
  ) dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  exp_t sb[$];
  int   applied = 0;
  int   errs    = 0;
  int   cyc     = 0;
  bit   busy_ok = 1'b1;

  // waveform generator state: 0 const, 1 square, 2 sine
  int mode = 0;
  int lo   = 0;
  int hi   = 0;
  int per  = 50;
  int n    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] wave(input int k);
    int v;
    case (mode)
      0: v = lo;
      1: v = ((k % per) < (per / 2)) ? lo : hi;
      default: v = $rtoi(128.5 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(k % 100) / 100.0));
    endcase
    return 8'(v);
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.ad_data = wave(n);
    n++;
  endtask

  // Monitor: busy must stay high while a measurement is outstanding
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc >= sb[0].t_start && bus.busy !== 1'b1) busy_ok = 1'b0;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        applied++;
        errs++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("vmax", int'(bus.vmax), e.vmax);
        chk("vmin", int'(bus.vmin), e.vmin);
        chk("vpp", int'(bus.vpp), e.vpp);
        chk("period", int'(bus.period), e.period);
        chk("no_signal", int'(bus.no_signal), e.nosig);
        chk("busy_held", int'(busy_ok), 1);
        if (e.lat > 0) chk("latency", cyc - e.t_start, e.lat);
      end
    end
  end

  task automatic measure(input int vmax, input int vmin, input int vpp,
                         input int period, input int nosig, input int lat,
                         input bit repulse);
    exp_t e;
    int   b;
    tick();
    bus.start = 1'b1;
    e.vmax = vmax; e.vmin = vmin; e.vpp = vpp; e.period = period;
    e.nosig = nosig; e.lat = lat; e.t_start = cyc + 1;
    busy_ok = 1'b1;
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
    if (repulse) begin
      repeat (10) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    b = 0;
    while (sb.size() > 0 && b < 2000) begin
      tick();
      b++;
    end
    if (sb.size() > 0) begin
      applied++;
      errs++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", b);
      sb.delete();
    end
    repeat (3) tick();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_vmax"}, int'(bus.vmax), 0);
    chk({tag, "_vmin"}, int'(bus.vmin), 0);
    chk({tag, "_vpp"}, int'(bus.vpp), 0);
    chk({tag, "_period"}, int'(bus.period), 0);
    chk({tag, "_no_signal"}, int'(bus.no_signal), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    int ts;
    bus.start   = 1'b0;
    bus.ad_data = '0;
    repeat (3) tick();
    chk_cleared("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    // constant input, with an extra start during PEAK that must be ignored
    mode = 0; lo = 100;
    measure(100, 100, 0, 0, 1, 258, 1'b1);

    // square 0/200, period 50
    mode = 1; lo = 0; hi = 200; per = 50;
    measure(200, 0, 200, 50, 0, 0, 1'b0);

    // sine 28..228, period 100
    mode = 2;
    measure(228, 28, 200, 100, 0, 0, 1'b0);
    chk("thr_lo", int'(dut.thr_lo_q), 120);
    chk("thr_hi", int'(dut.thr_hi_q), 136);

    // square 0/200, period 600: peak window straddles a rising edge, period pass times out
    mode = 1; lo = 0; hi = 200; per = 600; n = 150;
    measure(200, 0, 200, 0, 1, 514, 1'b0);

    // small square 100/110: amplitude below the hysteresis band
    mode = 1; lo = 100; hi = 110; per = 50;
    measure(110, 100, 10, 0, 1, 258, 1'b0);

    // start, re-pulse in PEAK, then asynchronous reset in PERIOD
    mode = 1; lo = 0; hi = 200; per = 50;
    tick();
    bus.start = 1'b1;
    ts = cyc + 1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < ts + 272) tick();
    chk("busy_before_rst", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_cleared("async_rst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (300) tick();

    // fresh measurement after reset
    measure(200, 0, 200, 50, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
